// File: rtl/top_level_moving_average_if.sv
// ---------------------------------------------------------------------------
// top_level_moving_average_if
// Board-side signal bundle for the moving-average demonstrator.
//   toggleBtn  : pushbutton, active-low, asynchronous to the clock
//   HEX3..HEX0 : seven-segment digits, active-low segments (bit0 = a .. bit6 = g)
//   LEDG       : status LEDs, active-high
// The master modport is the board/bench side and drives the button.
// The slave modport is the design side and drives the display.
// ---------------------------------------------------------------------------
interface top_level_moving_average_if;
  logic       toggleBtn;
  logic [6:0] HEX3;
  logic [6:0] HEX2;
  logic [6:0] HEX1;
  logic [6:0] HEX0;
  logic [7:0] LEDG;

  modport master (
    output toggleBtn,
    input  HEX3, HEX2, HEX1, HEX0, LEDG
  );

  modport slave (
    input  toggleBtn,
    output HEX3, HEX2, HEX1, HEX0, LEDG
  );
endinterface

// File: rtl/top_level_moving_average.sv
// ---------------------------------------------------------------------------
// top_level_moving_average
// An internal 16-bit LFSR produces one pseudo-random sample every SAMPLE_DIV
// clocks. An N = 2**LOG2_N entry moving average is kept over those samples.
// The seven-segment digits show either the average (mode 0) or the latest raw
// sample (mode 1). Each debounced press of toggleBtn flips the mode.
//
// Ports
//   CLOCK_50 : system clock, all logic on the rising edge
//   reset_n  : synchronous, active-low reset
//   io       : slave side of top_level_moving_average_if
//              (toggleBtn in, HEX3..HEX0 out, LEDG out)
//
// LEDG layout: [7] mode, [6] window full, [5:3] zero, [2:0] write index.
// ---------------------------------------------------------------------------
module top_level_moving_average #(
  parameter int unsigned SAMPLE_DIV      = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOG2_N          = 3
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  top_level_moving_average_if.slave     io
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = 16 + LOG2_N;
  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  // Sample generator state
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       lfsr_q, lfsr_d;

  // Averager state
  logic [15:0]       win_q [N];
  logic [15:0]       win_d [N];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG2_N-1:0] idx_q, idx_d;
  logic [15:0]       latest_q, latest_d;
  logic              full_q, full_d;

  // Button state
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              deb_q, deb_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              mode_q, mode_d;

  // Combinational helpers
  logic              tick;
  logic [15:0]       sample;
  logic [15:0]       avg;
  logic [15:0]       value;

  // Active-low seven-segment encoding, bit6..bit0 = g..a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Sample tick, LFSR step and window update. On a tick the newly shifted
  // LFSR value enters the window slot at idx while the value it replaces is
  // subtracted from the running sum, so the sum always covers exactly the
  // last N samples (empty slots hold 0 during the fill phase).
  always_comb begin
    div_d    = div_q;
    lfsr_d   = lfsr_q;
    win_d    = win_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    latest_d = latest_q;
    full_d   = full_q;

    tick   = (div_q == DIV_LAST);
    sample = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    if (tick) begin
      div_d        = '0;
      lfsr_d       = sample;
      win_d[idx_q] = sample;
      sum_d        = sum_q + {{LOG2_N{1'b0}}, sample} - {{LOG2_N{1'b0}}, win_q[idx_q]};
      idx_d        = idx_q + 1'b1;
      latest_d     = sample;
      if (idx_q == {LOG2_N{1'b1}}) begin
        full_d = 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Button path: two-flop synchronizer, then a debouncer that only adopts the
  // synchronized level after it has disagreed for DEBOUNCE_CYCLES consecutive
  // cycles. A debounced falling edge (press) flips the display mode in the
  // same cycle that the debounced level changes.
  always_comb begin
    sync1_d  = io.toggleBtn;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    mode_d   = mode_q;

    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    if (deb_q && !deb_d) begin
      mode_d = ~mode_q;
    end
  end

  // State register. Reset wins over any tick or button event in the same
  // cycle and clears the whole window.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      div_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      for (int i = 0; i < int'(N); i++) begin
        win_q[i] <= '0;
      end
      sum_q    <= '0;
      idx_q    <= '0;
      latest_q <= '0;
      full_q   <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      deb_q    <= 1'b1;
      db_cnt_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      lfsr_q   <= lfsr_d;
      win_q    <= win_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      latest_q <= latest_d;
      full_q   <= full_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      mode_q   <= mode_d;
    end
  end

  // Divide by N is a plain bit-select of the running sum (truncating).
  assign avg   = sum_q[SUM_W-1:LOG2_N];
  assign value = mode_q ? latest_q : avg;

  assign io.HEX3 = seg7(value[15:12]);
  assign io.HEX2 = seg7(value[11:8]);
  assign io.HEX1 = seg7(value[7:4]);
  assign io.HEX0 = seg7(value[3:0]);
  assign io.LEDG = {mode_q, full_q, 3'b000, 3'(idx_q)};

endmodule

// File: tb/tb_top_level_moving_average.sv
// ---------------------------------------------------------------------------
// tb_top_level_moving_average
// Directed bench for top_level_moving_average. Stimulus pushes expected
// display/LED values into a scoreboard queue tagged with the cycle they apply
// to; an independent monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_top_level_moving_average;

  localparam int DIV = 1000;
  localparam int DEB = 16;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;

  typedef struct {
    int          cyc;
    string       name;
    logic [27:0] hex;
    logic [7:0]  ledg;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference model of the visible state
  logic [15:0] m_lfsr;
  logic [15:0] m_win [8];
  int          m_sum;
  int          m_idx;
  logic        m_full;
  logic        m_mode;
  logic [15:0] m_latest;
  int          since_reset;

  top_level_moving_average_if bus();

  top_level_moving_average #(
    .SAMPLE_DIV     (DIV),
    .DEBOUNCE_CYCLES(DEB),
    .LOG2_N         (3)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] hex4(input logic [15:0] v);
    return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  task automatic modelReset();
    m_lfsr   = 16'hACE1;
    for (int i = 0; i < 8; i++) m_win[i] = '0;
    m_sum    = 0;
    m_idx    = 0;
    m_full   = 1'b0;
    m_mode   = 1'b0;
    m_latest = '0;
    since_reset = 0;
  endtask

  task automatic modelTick();
    m_lfsr = lfsr_step(m_lfsr);
    m_sum  = m_sum + int'(m_lfsr) - int'(m_win[m_idx]);
    m_win[m_idx] = m_lfsr;
    if (m_idx == 7) m_full = 1'b1;
    m_idx    = (m_idx + 1) % 8;
    m_latest = m_lfsr;
  endtask

  // One clock: inputs settle #1 after the edge, the model follows the tick.
  task automatic step();
    @(posedge clk);
    #1;
    since_reset++;
    if (since_reset % DIV == 0) modelTick();
  endtask

  task automatic applyStimulus(input logic btn, input int cycles);
    bus.toggleBtn = btn;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    modelReset();
  endtask

  task automatic checkRaw(input string name, input logic [27:0] hex, input logic [7:0] ledg);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.name = name;
    e.hex  = hex;
    e.ledg = ledg;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    logic [15:0] v;
    logic [15:0] avg;
    avg = 16'(m_sum >> 3);
    v   = m_mode ? m_latest : avg;
    checkRaw(name, hex4(v), {m_mode, m_full, 3'b000, 3'(m_idx)});
  endtask

  // Monitor: compares every scoreboard entry due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t        e;
      logic [27:0] act;
      e   = sb.pop_front();
      act = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
      n_checks++;
      if (e.cyc != cyc_cnt || act !== e.hex || bus.LEDG !== e.ledg) begin
        n_fail++;
        $display("[TB] FAIL %s: got HEX=%h LEDG=%h, expected HEX=%h LEDG=%h",
                 e.name, act, bus.LEDG, e.hex, e.ledg);
      end
    end
  end

  initial begin
    logic [15:0] l;
    int          s;

    bus.toggleBtn = 1'b1;
    doReset();
    checkRaw("reset", {S0, S0, S0, S0}, 8'h00);

    applyStimulus(1'b1, DIV - 1);
    checkOutput("pre_tick1");
    applyStimulus(1'b1, 1);
    checkRaw("tick1", {S0, SB, S3, S8}, 8'h01);

    for (int t = 2; t <= 8; t++) begin
      applyStimulus(1'b1, DIV);
      checkOutput($sformatf("tick%0d", t));
    end
    checkRaw("tick8_full", hex4(16'(m_sum >> 3)), 8'h40);

    // Independent window sum: outputs 2..9 of the LFSR
    applyStimulus(1'b1, DIV);
    l = 16'hACE1;
    s = 0;
    for (int i = 1; i <= 9; i++) begin
      l = lfsr_step(l);
      if (i >= 2) s += int'(l);
    end
    checkRaw("tick9_wrap", hex4(16'(s >> 3)), 8'h41);

    // Press held for 100 us: toggles after 2 + DEB cycles
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 2 + DEB - 1);
    checkOutput("btn_not_yet");
    applyStimulus(1'b0, 1);
    m_mode = 1'b1;
    checkOutput("btn_press");
    applyStimulus(1'b0, 5000 - 2 - DEB);
    checkOutput("btn_hold");
    applyStimulus(1'b1, 40);
    checkOutput("btn_release");
    applyStimulus(1'b0, 2 + DEB);
    m_mode = 1'b0;
    checkOutput("btn_press2");
    applyStimulus(1'b1, 40);

    // Short glitch is ignored
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 40);
    checkOutput("glitch");

    // Mid-operation reset after 5 ticks, with mode set
    doReset();
    applyStimulus(1'b1, 5 * DIV);
    checkOutput("five_ticks");
    applyStimulus(1'b0, 2 + DEB);
    m_mode = 1'b1;
    applyStimulus(1'b1, 40);
    checkOutput("five_ticks_mode1");
    doReset();
    checkRaw("mid_reset", {S0, S0, S0, S0}, 8'h00);
    applyStimulus(1'b1, DIV);
    checkRaw("reset_tick1", {S0, SB, S3, S8}, 8'h01);
    applyStimulus(1'b0, 2 + DEB);
    checkRaw("latest_view", {S5, S9, SC, S3}, 8'h81);
    applyStimulus(1'b1, 40);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
